// File: rtl/sqrt_pkg.sv
// Shared constants and types for the square-root family of blocks.
// The result squarer uses the state encoding defined here.
package sqrt_pkg;

    localparam int RW   = 8;
    localparam int XW   = 16;
    localparam int RESW = XW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sq_state_t;

endpackage

// File: rtl/sq_shift_add_step.sv
// One shift-add partial-product step of the root squarer.
// When the selected root bit is set, the shifted root is added.
module sq_shift_add_step #(
    parameter int RW = 8,
    parameter int XW = 16,
    parameter int CW = $clog2(RW)
) (
    input  logic [XW-1:0] acc,
    input  logic [RW-1:0] root,
    input  logic [CW-1:0] idx,
    input  logic          bit_set,
    output logic [XW-1:0] acc_nxt
);

    logic [XW-1:0] partial;

    always_comb begin
        partial = XW'(root) << idx;
        acc_nxt = acc;
        if (bit_set) begin
            acc_nxt = acc + partial;
        end
    end

endmodule

// File: rtl/sqrt_result_squarer.sv
// Squares an approximate root by iterative shift-add and reports
// the residual radicand - root^2 as an accuracy monitor.
module sqrt_result_squarer #(
    parameter int RW = 8,
    parameter int XW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] root,
    input  logic [XW-1:0] radicand,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] square,
    output logic [XW:0]   residual,
    output logic          exact,
    output logic          over
);

    import sqrt_pkg::*;

    localparam int CW = $clog2(RW);
    localparam logic [CW-1:0] LAST = CW'(RW - 1);

    sq_state_t state_q, state_d;

    logic [RW-1:0] root_q, root_d;
    logic [XW-1:0] rad_q, rad_d;
    logic [XW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] square_q, square_d;
    logic [XW:0]   residual_q, residual_d;
    logic          exact_q, exact_d;
    logic          over_q, over_d;

    logic [XW-1:0] acc_nxt;
    logic [XW:0]   diff;
    logic          last_step;

    sq_shift_add_step #(
        .RW (RW),
        .XW (XW),
        .CW (CW)
    ) u_step (
        .acc     (acc_q),
        .root    (root_q),
        .idx     (cnt_q),
        .bit_set (root_q[cnt_q]),
        .acc_nxt (acc_nxt)
    );

    assign last_step = (cnt_q == LAST);
    assign diff      = {1'b0, rad_q} - {1'b0, acc_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = BUSY;
            BUSY: if (last_step) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Result registers only change on the BUSY->DONE edge and hold otherwise.
    always_comb begin
        root_d     = root_q;
        rad_d      = rad_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        square_d   = square_q;
        residual_d = residual_q;
        exact_d    = exact_q;
        over_d     = over_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    root_d = root;
                    rad_d  = radicand;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            BUSY: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    square_d   = acc_nxt;
                    residual_d = diff;
                    exact_d    = (diff == '0);
                    over_d     = diff[XW];
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_q     <= '0;
            rad_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            square_q   <= '0;
            residual_q <= '0;
            exact_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            root_q     <= root_d;
            rad_q      <= rad_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            square_q   <= square_d;
            residual_q <= residual_d;
            exact_q    <= exact_d;
            over_q     <= over_d;
        end
    end

    assign square   = square_q;
    assign residual = residual_q;
    assign exact    = exact_q;
    assign over     = over_q;

endmodule
